// File: rtl/sram_pkg.sv
// Shared types and default geometry/timing for the SRAM macro, its array,
// sense-amp column and the read/write sequencer.
package sram_pkg;

    localparam int unsigned ROWS_DEF      = 16;
    localparam int unsigned COLS_DEF      = 16;
    localparam int unsigned ADDR_W_DEF    = 4;
    localparam int unsigned PRECH_CYC_DEF = 2;
    localparam int unsigned DEV_CYC_DEF   = 3;
    localparam int unsigned WR_CYC_DEF    = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRECH   = 3'd1,
        ST_DEVELOP = 3'd2,
        ST_SENSE   = 3'd3,
        ST_WRITE   = 3'd4,
        ST_RESP    = 3'd5
    } state_e;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sram_row_decoder.sv
// One-hot wordline decoder; rows outside 0..ROWS-1 decode to no wordline.
module sram_row_decoder #(
    parameter int unsigned ROWS   = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              en_i,
    output logic [ROWS-1:0]   wl_en_o
);

    always_comb begin
        wl_en_o = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            wl_en_o[r] = en_i && (32'(addr_i) == r);
        end
    end

endmodule

// File: rtl/sram_rw_sequencer.sv
// Host-facing read/write sequencer for the SRAM macro: precharge, wordline,
// bitline development, sense capture and write-driver timing.
module sram_rw_sequencer
    import sram_pkg::*;
#(
    parameter int unsigned ROWS      = ROWS_DEF,
    parameter int unsigned COLS      = COLS_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned PRECH_CYC = PRECH_CYC_DEF,
    parameter int unsigned DEV_CYC   = DEV_CYC_DEF,
    parameter int unsigned WR_CYC    = WR_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [COLS-1:0]   req_wdata,
    output logic              rsp_valid,
    output logic [COLS-1:0]   rsp_rdata,
    output logic              prech_en,
    output logic [ROWS-1:0]   wl_en,
    output logic              wr_en,
    output logic [COLS-1:0]   wr_data,
    output logic              sa_en,
    input  logic [COLS-1:0]   preout,
    output logic              err_addr
);

    localparam int unsigned CNT_MAX = max3(PRECH_CYC, DEV_CYC, WR_CYC);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic                addr_ok_q, addr_ok_d;
    logic [COLS-1:0]     wdata_q, wdata_d;

    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [COLS-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                prech_en_q, prech_en_d;
    logic [ROWS-1:0]     wl_en_q;
    logic                wr_en_q, wr_en_d;
    logic [COLS-1:0]     wr_data_q, wr_data_d;
    logic                sa_en_q, sa_en_d;
    logic                err_addr_q, err_addr_d;

    logic                wl_act_c;
    logic [ROWS-1:0]     wl_dec_c;
    logic                in_range_c;

    assign in_range_c = (32'(req_addr) < ROWS);

    // Next state plus outputs derived from the next state, so every pin is a flop.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        we_d        = we_q;
        addr_ok_d   = addr_ok_q;
        wdata_d     = wdata_q;
        err_addr_d  = err_addr_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_d    = req_addr;
                    we_d      = req_we;
                    wdata_d   = req_wdata;
                    addr_ok_d = in_range_c;
                    if (!in_range_c) begin
                        err_addr_d = 1'b1;
                    end
                    cnt_d   = CNT_W'(PRECH_CYC - 1);
                    state_d = ST_PRECH;
                end
            end
            ST_PRECH: begin
                if (cnt_q == '0) begin
                    if (we_q) begin
                        cnt_d   = CNT_W'(WR_CYC - 1);
                        state_d = ST_WRITE;
                    end else begin
                        cnt_d   = CNT_W'(DEV_CYC - 1);
                        state_d = ST_DEVELOP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DEVELOP: begin
                if (cnt_q == '0) begin
                    state_d = ST_SENSE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_SENSE: begin
                // Out-of-range reads never fired a wordline, so return zero.
                rsp_rdata_d = addr_ok_q ? preout : '0;
                state_d     = ST_RESP;
            end
            ST_WRITE: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
        prech_en_d  = (state_d == ST_IDLE) || (state_d == ST_PRECH) || (state_d == ST_RESP);
        wl_act_c    = (state_d == ST_DEVELOP) || (state_d == ST_SENSE) || (state_d == ST_WRITE);
        wr_en_d     = (state_d == ST_WRITE);
        wr_data_d   = (state_d == ST_WRITE) ? wdata_q : '0;
        sa_en_d     = (state_d == ST_SENSE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    sram_row_decoder #(
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_row_decoder (
        .addr_i  (addr_q),
        .en_i    (wl_act_c),
        .wl_en_o (wl_dec_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            addr_ok_q   <= 1'b0;
            wdata_q     <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            prech_en_q  <= 1'b1;
            wl_en_q     <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            sa_en_q     <= 1'b0;
            err_addr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            addr_ok_q   <= addr_ok_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            prech_en_q  <= prech_en_d;
            wl_en_q     <= wl_dec_c;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            sa_en_q     <= sa_en_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign prech_en  = prech_en_q;
    assign wl_en     = wl_en_q;
    assign wr_en     = wr_en_q;
    assign wr_data   = wr_data_q;
    assign sa_en     = sa_en_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_sram_rw_sequencer.sv
// Directed bench for sram_rw_sequencer: default-size instance A plus a
// ROWS=12 instance B for the out-of-range address case.
module tb_sram_rw_sequencer;

    localparam int unsigned COLS   = 16;
    localparam int unsigned ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [COLS-1:0]   req_wdata, preout;

    logic              req_ready, rsp_valid, prech_en, wr_en, sa_en, err_addr;
    logic [COLS-1:0]   rsp_rdata, wr_data;
    logic [15:0]       wl_en;

    logic              b_req_valid;
    logic              b_req_ready, b_rsp_valid, b_prech_en, b_wr_en, b_sa_en, b_err_addr;
    logic [COLS-1:0]   b_rsp_rdata, b_wr_data;
    logic [11:0]       b_wl_en;

    int n_checks = 0;
    int n_errors = 0;
    int n_viol   = 0;

    always #5 clk = ~clk;

    sram_rw_sequencer u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .prech_en  (prech_en),
        .wl_en     (wl_en),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .sa_en     (sa_en),
        .preout    (preout),
        .err_addr  (err_addr)
    );

    sram_rw_sequencer #(.ROWS(12)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .req_valid (b_req_valid),
        .req_ready (b_req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (b_rsp_valid),
        .rsp_rdata (b_rsp_rdata),
        .prech_en  (b_prech_en),
        .wl_en     (b_wl_en),
        .wr_en     (b_wr_en),
        .wr_data   (b_wr_data),
        .sa_en     (b_sa_en),
        .preout    (preout),
        .err_addr  (b_err_addr)
    );

    // Array-safety invariants, watched on every falling edge outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            if ((|wl_en && prech_en) || (wr_en && sa_en) || !$onehot0(wl_en)) n_viol++;
            if ((|b_wl_en && b_prech_en) || (b_wr_en && b_sa_en) || !$onehot0(b_wl_en)) n_viol++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ctl = {prech_en, sa_en, wr_en, rsp_valid, req_ready}
    task automatic step_a(input string tag, input logic [4:0] ctl, input logic [15:0] wl,
                          input logic [15:0] wd);
        tick();
        check($sformatf("%s.prech", tag), 32'(prech_en),  32'(ctl[4]));
        check($sformatf("%s.sa", tag),    32'(sa_en),     32'(ctl[3]));
        check($sformatf("%s.wr", tag),    32'(wr_en),     32'(ctl[2]));
        check($sformatf("%s.rsp", tag),   32'(rsp_valid), 32'(ctl[1]));
        check($sformatf("%s.ready", tag), 32'(req_ready), 32'(ctl[0]));
        check($sformatf("%s.wl", tag),    32'(wl_en),     32'(wl));
        check($sformatf("%s.wdata", tag), 32'(wr_data),   32'(wd));
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        b_req_valid = 1'b0;
        req_we      = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        preout      = 16'h0F0F;

        repeat (3) tick();
        check("rst.ready", 32'(req_ready), 32'd0);
        check("rst.prech", 32'(prech_en), 32'd1);
        check("rst.wl", 32'(wl_en), 32'd0);
        check("rst.rdata", 32'(rsp_rdata), 32'd0);
        check("rst.err", 32'(err_addr), 32'd0);
        check("rst.b_ready", 32'(b_req_ready), 32'd0);

        rst = 1'b0;
        step_a("idle", 5'b10001, 16'h0000, 16'h0000);
        check("idle.rdata", 32'(rsp_rdata), 32'd0);

        // Read row 5: sense value presented only during the SENSE cycle.
        req_we = 1'b0; req_addr = 4'd5; req_valid = 1'b1;
        step_a("rd1", 5'b10000, 16'h0000, 16'h0000);
        req_valid = 1'b0;
        step_a("rd2", 5'b10000, 16'h0000, 16'h0000);
        step_a("rd3", 5'b00000, 16'h0020, 16'h0000);
        step_a("rd4", 5'b00000, 16'h0020, 16'h0000);
        step_a("rd5", 5'b00000, 16'h0020, 16'h0000);
        step_a("rd6", 5'b01000, 16'h0020, 16'h0000);
        preout = 16'hA5C3;
        step_a("rd7", 5'b10010, 16'h0000, 16'h0000);
        check("rd7.rdata", 32'(rsp_rdata), 32'h0000A5C3);
        preout = 16'h0F0F;
        step_a("rd8", 5'b10001, 16'h0000, 16'h0000);

        // Write row 15.
        req_we = 1'b1; req_addr = 4'd15; req_wdata = 16'h1234; req_valid = 1'b1;
        step_a("wr1", 5'b10000, 16'h0000, 16'h0000);
        req_valid = 1'b0;
        step_a("wr2", 5'b10000, 16'h0000, 16'h0000);
        step_a("wr3", 5'b00100, 16'h8000, 16'h1234);
        step_a("wr4", 5'b00100, 16'h8000, 16'h1234);
        step_a("wr5", 5'b10010, 16'h0000, 16'h0000);
        check("wr5.rdata", 32'(rsp_rdata), 32'h0000A5C3);
        step_a("wr6", 5'b10001, 16'h0000, 16'h0000);

        // Back-to-back: read row 2, then a write to row 3 held while busy.
        req_we = 1'b0; req_addr = 4'd2; req_valid = 1'b1;
        step_a("bb1", 5'b10000, 16'h0000, 16'h0000);
        req_we = 1'b1; req_addr = 4'd3; req_wdata = 16'hBEEF;
        step_a("bb2", 5'b10000, 16'h0000, 16'h0000);
        step_a("bb3", 5'b00000, 16'h0004, 16'h0000);
        step_a("bb4", 5'b00000, 16'h0004, 16'h0000);
        step_a("bb5", 5'b00000, 16'h0004, 16'h0000);
        step_a("bb6", 5'b01000, 16'h0004, 16'h0000);
        preout = 16'h1357;
        step_a("bb7", 5'b10010, 16'h0000, 16'h0000);
        check("bb7.rdata", 32'(rsp_rdata), 32'h00001357);
        preout = 16'h0F0F;
        step_a("bb8", 5'b10001, 16'h0000, 16'h0000);
        step_a("bb9", 5'b10000, 16'h0000, 16'h0000);
        req_valid = 1'b0;
        step_a("bb10", 5'b10000, 16'h0000, 16'h0000);
        step_a("bb11", 5'b00100, 16'h0008, 16'hBEEF);
        step_a("bb12", 5'b00100, 16'h0008, 16'hBEEF);
        step_a("bb13", 5'b10010, 16'h0000, 16'h0000);
        check("bb13.rdata", 32'(rsp_rdata), 32'h00001357);
        step_a("bb14", 5'b10001, 16'h0000, 16'h0000);

        // Reset in the middle of bitline development aborts the read.
        req_we = 1'b0; req_addr = 4'd7; req_valid = 1'b1;
        step_a("rs1", 5'b10000, 16'h0000, 16'h0000);
        req_valid = 1'b0;
        step_a("rs2", 5'b10000, 16'h0000, 16'h0000);
        step_a("rs3", 5'b00000, 16'h0080, 16'h0000);
        step_a("rs4", 5'b00000, 16'h0080, 16'h0000);
        rst = 1'b1;
        step_a("rs5", 5'b10000, 16'h0000, 16'h0000);
        check("rs5.rdata", 32'(rsp_rdata), 32'd0);
        rst = 1'b0;
        step_a("rs6", 5'b10001, 16'h0000, 16'h0000);
        step_a("rs7", 5'b10001, 16'h0000, 16'h0000);

        // ROWS=12 instance: read of row 13 is out of range.
        check("b.ready", 32'(b_req_ready), 32'd1);
        check("b.err0", 32'(b_err_addr), 32'd0);
        req_we = 1'b0; req_addr = 4'd13; b_req_valid = 1'b1; preout = 16'hFFFF;
        for (int k = 1; k <= 8; k++) begin
            tick();
            b_req_valid = 1'b0;
            check($sformatf("b%0d.wl", k), 32'(b_wl_en), 32'd0);
            check($sformatf("b%0d.err", k), 32'(b_err_addr), 32'd1);
            check($sformatf("b%0d.rsp", k), 32'(b_rsp_valid), (k == 7) ? 32'd1 : 32'd0);
        end
        check("b.rdata", 32'(b_rsp_rdata), 32'd0);
        check("a.err", 32'(err_addr), 32'd0);

        check("invariants", 32'(n_viol), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_rw_sequencer.md
Name: sram_rw_sequencer

Overview:
Cycle-accurate read/write controller for the mixed-signal SRAM macro. It accepts single-word requests from a host over a valid/ready handshake and sequences bitline precharge, wordline assertion, bitline development, sense-amplifier evaluation and write-driver enable. It captures the digital comparator outputs (preout) into a read-data register. It sits between the host bus and the analog array/sense-amp column.

Parameters:
ROWS, 16, number of wordlines
COLS, 16, word width, equal to the sense-amp column count
ADDR_W, 4, row address width; must satisfy ROWS <= 2**ADDR_W
PRECH_CYC, 2, precharge duration in clocks (>=1)
DEV_CYC, 3, bitline development duration in clocks before sensing (>=1)
WR_CYC, 2, write-driver active duration in clocks (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_valid  in  1  host request valid
req_ready  out  1  controller can accept a request
req_we  in  1  1=write, 0=read
req_addr  in  ADDR_W  row address
req_wdata  in  COLS  write data
rsp_valid  out  1  one-cycle pulse: access complete
rsp_rdata  out  COLS  read data, held until the next read completes
prech_en  out  1  bitline precharge enable
wl_en  out  ROWS  one-hot wordline enables
wr_en  out  1  write-driver enable
wr_data  out  COLS  column write data to drivers
sa_en  out  1  sense-amp evaluate/capture strobe
preout  in  COLS  sense-amp digital outputs
err_addr  out  1  sticky flag: request with req_addr >= ROWS was received

Behaviour:
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_rdata=0, prech_en=1 (bitlines parked precharged), wl_en=0, wr_en=0, wr_data=0, sa_en=0, err_addr=0.
  - State goes to IDLE.
  - Reset asserted mid-access aborts it immediately at that edge. No response is issued.
- FSM states: IDLE, PRECH, DEVELOP, SENSE, WRITE, RESP.
- IDLE:
  - req_ready=1 and prech_en=1.
  - On req_valid&&req_ready, latch addr, we and wdata, then go to PRECH.
  - An address >= ROWS sets err_addr. The request still completes with rsp_valid, but no wordline fires and a read returns 0.
- PRECH:
  - prech_en=1 for exactly PRECH_CYC cycles, using a down-counter loaded on entry.
  - Then go to DEVELOP on a read, or WRITE on a write.
- DEVELOP:
  - prech_en=0 and wl_en[addr]=1 for DEV_CYC cycles, then go to SENSE.
- SENSE (1 cycle):
  - wl_en held, sa_en=1.
  - rsp_rdata <= preout at the end of this cycle.
  - Go to RESP.
- WRITE:
  - prech_en=0, wl_en[addr]=1, wr_en=1, wr_data=latched wdata for WR_CYC cycles.
  - Then go to RESP.
- RESP (1 cycle):
  - rsp_valid=1; wl_en=0, wr_en=0, sa_en=0; prech_en=1.
  - Go to IDLE.
- Outputs are registered and glitch-free.
- Invariants:
  - wl_en is never asserted while prech_en=1.
  - wr_en and sa_en are never asserted together.
  - At most one bit of wl_en is set.
- Latency from the accept edge to rsp_valid:
  - read = PRECH_CYC+DEV_CYC+2 clocks
  - write = PRECH_CYC+WR_CYC+1 clocks
- Handshake: req_ready is deasserted from the accept cycle until the controller is back in IDLE. Accepted throughput is one request per (latency+1) cycles. req_valid while busy is ignored; the host must hold it.
- rsp_rdata is unchanged by writes.
- err_addr clears only on rst.

Decomposition:
- Shared package sram_pkg holds:
  - the state enum typedef (IDLE..RESP);
  - timing defaults PRECH_CYC_DEF, DEV_CYC_DEF and WR_CYC_DEF;
  - the COLS/ROWS defaults shared with the array and sense-amp column.
- One natural sub-module, sram_row_decoder: a combinational one-hot decoder with enable and range check, taking addr and an enable and producing wl_en.
- The phase down-counter stays inline in the FSM.

Test Plan:
- Reset, then idle -> prech_en=1, wl_en=0, req_ready=1 one cycle after reset release; rsp_rdata=0.
- Read addr=5 with preout driven 16'hA5C3 during SENSE (default params) -> prech_en high for 2 cycles, wl_en=16'h0020 for 4 cycles with sa_en high in the last, rsp_valid pulse 7 clocks after accept, rsp_rdata=16'hA5C3.
- Write addr=15 wdata=16'h1234 -> wl_en=16'h8000 and wr_en=1 for 2 cycles with wr_data=16'h1234, rsp_valid 5 clocks after accept, rsp_rdata unchanged.
- req_valid held high with back-to-back read then write -> second accept occurs only after RESP; req_ready=0 throughout the first access; assertions confirm no wl_en/prech_en overlap.
- Reset asserted during DEVELOP -> next cycle wl_en=0, sa_en=0, prech_en=1, no rsp_valid, state IDLE.
- Parameter ROWS=12 with a read to addr=13 -> err_addr=1 sticky, wl_en stays 0, rsp_valid issued with rsp_rdata=0.
